// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver (LSB first) with a runtime bit divisor.
// Samples each bit at its midpoint, drops start glitches, and flags a stop
// bit sampled low as a framing error. A line held low after a framing error
// is treated as a break and yields only one error pulse.
module uart_rx #(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        rx_en,
  input  logic [15:0] CLKS_PER_BIT,
  input  logic        i_RX_Serial,
  output logic [7:0]  o_RX_Byte,
  output logic        o_RX_Done,
  output logic        o_frame_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_e;

  state_e                 state_q;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rxs;
  logic [15:0]            cnt_q;
  logic [2:0]             idx_q;
  logic [7:0]             shift_q;
  logic [15:0]            half_m1;
  logic [15:0]            cpb_m1;

  // Terminal counts: half a bit to reach mid start bit, a full bit between samples.
  assign half_m1 = {1'b0, CLKS_PER_BIT[15:1]} - 16'd1;
  assign cpb_m1  = CLKS_PER_BIT - 16'd1;
  assign rxs     = sync_q[SYNC_STAGES-1];

  // Metastability synchronizer for the asynchronous serial line; idles high.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) sync_q <= '1;
    else         sync_q <= {sync_q[SYNC_STAGES-2:0], i_RX_Serial};
  end

  // Frame FSM; the done/error pulses are registered and default low each cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      shift_q     <= '0;
      o_RX_Byte   <= 8'h00;
      o_RX_Done   <= 1'b0;
      o_frame_err <= 1'b0;
    end else begin
      o_RX_Done   <= 1'b0;
      o_frame_err <= 1'b0;
      case (state_q)
        S_IDLE: begin
          cnt_q <= '0;
          idx_q <= '0;
          // rx_en only gates new starts; a frame in flight always completes.
          if (rx_en && !rxs) state_q <= S_START;
        end
        S_START: begin
          if (cnt_q == half_m1) begin
            cnt_q   <= '0;
            // Line back high at mid start bit: a glitch, not a frame.
            state_q <= rxs ? S_IDLE : S_DATA;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        S_DATA: begin
          if (cnt_q == cpb_m1) begin
            cnt_q          <= '0;
            shift_q[idx_q] <= rxs;
            if (idx_q == 3'd7) state_q <= S_STOP;
            else               idx_q   <= idx_q + 3'd1;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        S_STOP: begin
          if (cnt_q == cpb_m1) begin
            cnt_q <= '0;
            if (rxs) begin
              o_RX_Byte <= shift_q;
              o_RX_Done <= 1'b1;
              state_q   <= S_IDLE;
            end else begin
              // Keep the last good byte; wait out a possible break.
              o_frame_err <= 1'b1;
              state_q     <= S_BREAK;
            end
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        S_BREAK: begin
          cnt_q <= '0;
          if (rxs) state_q <= S_IDLE;
        end
        default: begin
          cnt_q   <= '0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: directed scenarios plus random bytes/divisors, compared
// against a frame-level model (expected pulse cycle, byte and kind per frame).
module tb_uart_rx;

  localparam int SYNC = 2;

  logic        clk_i;
  logic        rst_ni;
  logic        rx_en;
  logic [15:0] cpb;
  logic        ser;
  logic [7:0]  o_RX_Byte;
  logic        o_RX_Done;
  logic        o_frame_err;

  uart_rx #(.SYNC_STAGES(SYNC)) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .rx_en        (rx_en),
    .CLKS_PER_BIT (cpb),
    .i_RX_Serial  (ser),
    .o_RX_Byte    (o_RX_Byte),
    .o_RX_Done    (o_RX_Done),
    .o_frame_err  (o_frame_err)
  );

  typedef struct {
    int         cyc;
    logic [7:0] b;
    logic       err;
  } ev_t;

  ev_t        exp_q[$];
  ev_t        got_q[$];
  int         cyc = 0;
  int         n_assert = 0;
  int         n_fail = 0;
  logic [7:0] last_good = 8'h00;
  int         last_t0 = 0;
  logic       done_prev = 1'b0;
  logic       err_prev = 1'b0;

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) cyc <= cyc + 1;

  // Record every pulse; each must be isolated and never coincide with the other.
  always @(negedge clk_i) begin
    if (rst_ni && (o_RX_Done || o_frame_err)) begin
      n_assert++;
      assert (!(o_RX_Done && o_frame_err) && !done_prev && !err_prev) else begin
        n_fail++;
        $error("FAIL pulse_shape: done=%0b err=%0b prev_done=%0b prev_err=%0b, required one isolated pulse",
               o_RX_Done, o_frame_err, done_prev, err_prev);
      end
      got_q.push_back('{cyc, o_RX_Byte, o_frame_err});
    end
    done_prev = o_RX_Done;
    err_prev  = o_frame_err;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Model: a frame started while rx_en is high yields one pulse at
  // start + SYNC + HALF + 9*CPB + 1; good stop -> done with the byte,
  // bad stop -> error with the previously received byte.
  task automatic send_frame(input logic [7:0] b, input logic stop, input logic drop_en);
    int t_exp;
    last_t0 = cyc;
    t_exp   = cyc + SYNC + int'(cpb >> 1) + 9 * int'(cpb) + 1;
    if (rx_en) begin
      if (stop) begin
        exp_q.push_back('{t_exp, b, 1'b0});
        last_good = b;
      end else begin
        exp_q.push_back('{t_exp, last_good, 1'b1});
      end
    end
    ser = 1'b0;
    tick(int'(cpb));
    for (int i = 0; i < 8; i++) begin
      ser = b[i];
      if (drop_en && i == 2) rx_en = 1'b0;
      tick(int'(cpb));
    end
    ser = stop;
    tick(int'(cpb));
    if (stop) ser = 1'b1;
  endtask

  task automatic check_batch(input string tag);
    chk({tag, "_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      chk($sformatf("%s_cyc%0d", tag, i),  got_q[i].cyc, exp_q[i].cyc);
      chk($sformatf("%s_byte%0d", tag, i), got_q[i].b,   exp_q[i].b);
      chk($sformatf("%s_kind%0d", tag, i), got_q[i].err, exp_q[i].err);
    end
    chk({tag, "_hold"}, o_RX_Byte, last_good);
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    rst_ni = 1'b0;
    rx_en  = 1'b0;
    cpb    = 16'd16;
    ser    = 1'b1;
    #2;
    chk("reset_byte", o_RX_Byte, 8'h00);
    chk("reset_done", o_RX_Done, 1'b0);
    chk("reset_err",  o_frame_err, 1'b0);
    tick(3);
    rst_ni = 1'b1;
    tick(4);

    // 1: single frame, fixed latency of 153 cycles after rxs low
    rx_en = 1'b1;
    send_frame(8'hA5, 1'b1, 1'b0);
    tick(20);
    chk("t1_latency", (got_q.size() > 0) ? got_q[0].cyc - (last_t0 + SYNC) : -1, 153);
    check_batch("t1");

    // 2: zero-gap back-to-back frames, 160 cycles apart
    send_frame(8'h00, 1'b1, 1'b0);
    send_frame(8'hFF, 1'b1, 1'b0);
    tick(20);
    chk("t2_gap", (got_q.size() > 1) ? got_q[1].cyc - got_q[0].cyc : -1, 160);
    check_batch("t2");

    // 3: short low glitch is rejected
    ser = 1'b0;
    tick(5);
    ser = 1'b1;
    tick(40);
    check_batch("t3");

    // 4: bad stop bit followed by a long break, then a clean frame
    send_frame(8'h3C, 1'b0, 1'b0);
    tick(400);
    ser = 1'b1;
    tick(5);
    check_batch("t4_err");
    send_frame(8'h81, 1'b1, 1'b0);
    tick(20);
    check_batch("t4_ok");

    // 5: disabled receiver ignores a frame; disabling mid-frame does not abort
    rx_en = 1'b0;
    send_frame(8'h55, 1'b1, 1'b0);
    tick(20);
    check_batch("t5_off");
    rx_en = 1'b1;
    send_frame(8'h55, 1'b1, 1'b1);
    tick(20);
    check_batch("t5_drop");
    rx_en = 1'b1;
    tick(3);

    // 6: reset during bit 4 discards the frame and clears outputs at once
    ser = 1'b0;
    tick(16);
    for (int i = 0; i < 4; i++) begin
      ser = (i % 2 == 0);
      tick(16);
    end
    ser = 1'b0;
    tick(7);
    rst_ni = 1'b0;
    #1;
    chk("t6_rst_byte", o_RX_Byte, 8'h00);
    chk("t6_rst_done", o_RX_Done, 1'b0);
    chk("t6_rst_err",  o_frame_err, 1'b0);
    ser = 1'b1;
    tick(3);
    rst_ni = 1'b1;
    last_good = 8'h00;
    tick(5);
    check_batch("t6_idle");
    send_frame(8'hC3, 1'b1, 1'b0);
    tick(20);
    check_batch("t6_ok");

    // Random: divisor per batch, random bytes, gaps and occasional bad stop bits
    for (int k = 0; k < 4; k++) begin
      cpb = 16'($urandom_range(24, 4));
      tick(5);
      for (int f = 0; f < 3; f++) begin
        logic [7:0] b;
        logic       stop;
        b    = 8'($urandom);
        stop = ($urandom_range(3, 0) != 0);
        send_frame(b, stop, 1'b0);
        if (!stop) begin
          tick($urandom_range(30, 0));
          ser = 1'b1;
          tick(3 + $urandom_range(3, 0));
        end else begin
          tick($urandom_range(3, 0));
        end
      end
      tick(int'(cpb) + 20);
      check_batch($sformatf("rnd%0d", k));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
